// File: rtl/estagio_id.sv
// ---------------------------------------------------------------------------
// estagio_id -- instruction decode stage of a 5-stage MIPS-like pipeline.
//
// Holds the IF/ID pipeline register, the 32x32 register file, load-use hazard
// detection, in-ID branch/jump resolution and the ID/EX pipeline register.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   contador, instrucao     PC+4 and instruction from fetch
//   wb_escreve/reg/dado     register-file write port from write-back
//   ex_mem_read, ex_rt_in   load currently in EX and its destination register
//   hazard                  load-use stall request to fetch
//   BranchTaken, PCBranch   beq/bne outcome and target
//   jumpAddress, jumpReg    j/jal target and jr target
//   sel_pc                  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//   ex_*                    registered ID/EX fields (ex_valid=0 marks a bubble)
//
// Configuration macro
//   BYPASS_WB_EN  when defined, a write-back to the register being read in
//                 the same cycle is forwarded to that read port.
// ---------------------------------------------------------------------------
module estagio_id (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] contador,
  input  logic [31:0] instrucao,
  input  logic        wb_escreve,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_dado,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt_in,
  output logic        hazard,
  output logic        BranchTaken,
  output logic [31:0] PCBranch,
  output logic [31:0] jumpAddress,
  output logic [31:0] jumpReg,
  output logic [1:0]  sel_pc,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic        ex_valid
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // IF/ID pipeline register
  logic [31:0] ifid_instr_reg;
  logic [31:0] ifid_pc4_reg;

  // Decoded fields of the instruction sitting in IF/ID
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  logic        is_jal;

  assign opcode  = ifid_instr_reg[31:26];
  assign rs      = ifid_instr_reg[25:21];
  assign rt      = ifid_instr_reg[20:16];
  assign rd      = ifid_instr_reg[15:11];
  assign funct   = ifid_instr_reg[5:0];
  assign imm_ext = {{16{ifid_instr_reg[15]}}, ifid_instr_reg[15:0]};
  assign is_jal  = (opcode == OP_JAL);

  // -------------------------------------------------------------------------
  // Register file. Every entry must clear on reset, so it is built from
  // flops rather than block RAM. Entry 0 is hard-wired to zero, which also
  // discards any write aimed at it.
  // -------------------------------------------------------------------------
  logic [31:0] rf [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_entry
        logic [31:0] q_reg;
        always_ff @(posedge clock) begin
          if (reset) begin
            q_reg <= '0;
          end else if (wb_escreve && (wb_reg == 5'(gi))) begin
            q_reg <= wb_dado;
          end
        end
        assign rf[gi] = q_reg;
      end
    end
  endgenerate

  // Read ports
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  always_comb begin
    rs_data = rf[rs];
    rt_data = rf[rt];
`ifdef BYPASS_WB_EN
    // Write-through: the value being written this cycle is returned on a
    // matching port so branch compare and jr see it without waiting.
    if (wb_escreve && (wb_reg != 5'd0) && (wb_reg == rs)) rs_data = wb_dado;
    if (wb_escreve && (wb_reg != 5'd0) && (wb_reg == rt)) rt_data = wb_dado;
`endif
  end

  // Load-use hazard: the instruction in ID needs a register that the load
  // in EX has not produced yet. Register 0 never creates a dependency.
  assign hazard = ex_mem_read && (ex_rt_in != 5'd0) &&
                  ((ex_rt_in == rs) || (ex_rt_in == rt));

  // Branch and jump targets are always computed; sel_pc decides use.
  assign PCBranch    = ifid_pc4_reg + {{14{ifid_instr_reg[15]}}, ifid_instr_reg[15:0], 2'b00};
  assign jumpAddress = {ifid_pc4_reg[31:28], ifid_instr_reg[25:0], 2'b00};
  assign jumpReg     = rs_data;

  // Control resolution. While stalled the operands may be stale, so no
  // redirect is issued until the load data is available.
  always_comb begin
    sel_pc      = 2'b00;
    BranchTaken = 1'b0;
    if (!hazard) begin
      unique case (opcode)
        OP_BEQ: begin
          if (rs_data == rt_data) begin
            BranchTaken = 1'b1;
            sel_pc      = 2'b01;
          end
        end
        OP_BNE: begin
          if (rs_data != rt_data) begin
            BranchTaken = 1'b1;
            sel_pc      = 2'b01;
          end
        end
        OP_J, OP_JAL: sel_pc = 2'b10;
        OP_RTYPE: begin
          if (funct == FN_JR) sel_pc = 2'b11;
        end
        default: ;
      endcase
    end
  end

  // IF/ID: hold while stalled; replace the wrong-path fetch with a NOP
  // whenever this stage redirects the PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_instr_reg <= '0;
      ifid_pc4_reg   <= '0;
    end else if (!hazard) begin
      ifid_instr_reg <= (sel_pc != 2'b00) ? 32'd0 : instrucao;
      ifid_pc4_reg   <= contador;
    end
  end

  // ID/EX pipeline register
  logic [31:0] ex_pc4_reg;
  logic [31:0] ex_a_reg;
  logic [31:0] ex_b_reg;
  logic [31:0] ex_imm_reg;
  logic [4:0]  ex_rs_reg;
  logic [4:0]  ex_rt_reg;
  logic [4:0]  ex_rd_reg;
  logic [5:0]  ex_opcode_reg;
  logic [5:0]  ex_funct_reg;
  logic        ex_valid_reg;

  always_ff @(posedge clock) begin
    if (reset || hazard) begin
      // A stall inserts an all-zero bubble behind the load.
      ex_pc4_reg    <= '0;
      ex_a_reg      <= '0;
      ex_b_reg      <= '0;
      ex_imm_reg    <= '0;
      ex_rs_reg     <= '0;
      ex_rt_reg     <= '0;
      ex_rd_reg     <= '0;
      ex_opcode_reg <= '0;
      ex_funct_reg  <= '0;
      ex_valid_reg  <= 1'b0;
    end else begin
      ex_pc4_reg    <= ifid_pc4_reg;
      // jal links through the ALU: operand A carries the return address
      // and the destination is forced to r31.
      ex_a_reg      <= is_jal ? ifid_pc4_reg : rs_data;
      ex_b_reg      <= rt_data;
      ex_imm_reg    <= imm_ext;
      ex_rs_reg     <= rs;
      ex_rt_reg     <= rt;
      ex_rd_reg     <= is_jal ? 5'd31 : rd;
      ex_opcode_reg <= opcode;
      ex_funct_reg  <= funct;
      ex_valid_reg  <= 1'b1;
    end
  end

  assign ex_pc4    = ex_pc4_reg;
  assign ex_a      = ex_a_reg;
  assign ex_b      = ex_b_reg;
  assign ex_imm    = ex_imm_reg;
  assign ex_rs     = ex_rs_reg;
  assign ex_rt     = ex_rt_reg;
  assign ex_rd     = ex_rd_reg;
  assign ex_opcode = ex_opcode_reg;
  assign ex_funct  = ex_funct_reg;
  assign ex_valid  = ex_valid_reg;

endmodule

// File: doc/estagio_id.md
ESTAGIO_ID -- requirements
Module: estagio_id

Interface
REQ-001 SHALL have ports: clock  in  1  single rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have ports: contador  in  32  PC+4 from fetch; instrucao  in  32  fetched instruction.
REQ-003 SHALL have ports: wb_escreve  in  1  write enable; wb_reg  in  5  destination; wb_dado  in  32  write data.
REQ-004 SHALL have ports: ex_mem_read  in  1  instruction in EX is a load; ex_rt_in  in  5  load destination.
REQ-005 SHALL have ports: hazard  out  1  fetch stall; BranchTaken  out  1  branch taken; PCBranch  out  32  branch target.
REQ-006 SHALL have ports: jumpAddress  out  32  j/jal target; jumpReg  out  32  jr target; sel_pc  out  2  next-PC select (00 PC+4, 01 branch, 10 jump, 11 jr).
REQ-007 SHALL have registered ID/EX ports: ex_pc4 32, ex_a 32, ex_b 32, ex_imm 32, ex_rs 5, ex_rt 5, ex_rd 5, ex_opcode 6, ex_funct 6, ex_valid 1.

Function
REQ-008 SHALL hold an IF/ID register (instruction, PC+4); it loads on every edge unless hazard=1 (hold).
REQ-009 SHALL load instruction 0 (NOP) into IF/ID when sel_pc!=00 and hazard=0 (squash wrong-path fetch).
REQ-010 SHALL contain a 32x32 register file with 2 combinational read ports (rs=[25:21], rt=[20:16]) and 1 write port written on the clock edge.
REQ-011 SHALL ignore writes to register 0 and always read register 0 as 0.
REQ-012 SHALL assert hazard combinationally when ex_mem_read=1, ex_rt_in!=0, and ex_rt_in equals rs or rt of the IF/ID instruction.
REQ-013 SHALL load a bubble into ID/EX (all fields 0, ex_valid=0) while hazard=1; otherwise ID/EX loads decoded fields with ex_valid=1.
REQ-014 SHALL sign-extend imm[15:0] to ex_imm; PCBranch = IF/ID PC+4 + (sign-extended imm << 2), modulo 2^32.
REQ-015 SHALL resolve beq (opcode 000100) / bne (000101) in ID by comparing read data; BranchTaken=1 and sel_pc=01 when the condition holds.
REQ-016 SHALL drive sel_pc=10 for j (000010) / jal (000011), jumpAddress = {PC+4[31:28], instr[25:0], 00}.
REQ-017 SHALL drive sel_pc=11 for jr (opcode 000000, funct 001000), jumpReg = rs read data.
REQ-018 SHALL force sel_pc=00 and BranchTaken=0 while hazard=1 (control decisions wait for load data).
REQ-019 SHALL drive sel_pc=00, BranchTaken=0 for all other opcodes, including NOP.
REQ-020 SHALL take ex_rd from instr[15:11], except jal, which SHALL write 31 to ex_rd and PC+4 to ex_a.

Reset
REQ-021 SHALL, while reset=1 at an edge, clear IF/ID to 0, all ID/EX outputs to 0, and all 32 registers to 0.
REQ-022 SHALL give reset priority over hazard hold, squash, and register writes; combinational outputs follow the cleared state (hazard=0, sel_pc=00).
REQ-023 SHALL abort an in-flight load-use stall or taken branch on reset mid-operation, leaving no residual effect.

Configuration
REQ-024 SHALL, with BYPASS_WB_EN defined, return wb_dado on a read port when wb_escreve=1, wb_reg!=0 and wb_reg matches that port (same-cycle write-through), including for branch compare and jr.
REQ-025 SHALL, without BYPASS_WB_EN, return the pre-write register value in that cycle; the new value is visible from the next cycle.

Verification
REQ-026 SHALL cover: write r5=0x0000_0010, then beq r5,r5,+3 at PC+4=0x100 -> BranchTaken=1, sel_pc=01, PCBranch=0x10C; next IF/ID instruction = 0.
REQ-027 SHALL cover: ex_mem_read=1, ex_rt_in=8, IF/ID add rd,r8,r9 -> hazard=1, IF/ID holds, ID/EX ex_valid=0; hazard=0 on the following cycle with ex_mem_read=0.
REQ-028 SHALL cover: j 0x0000040 with PC+4=0x9000_0004 -> sel_pc=10, jumpAddress=0x9000_0100; jal -> ex_rd=31, ex_a=0x9000_0004.
REQ-029 SHALL cover: wb write r0=0xFFFF_FFFF, then read r0 -> 0; write r7=0xA5 with same-cycle read of r7 -> 0xA5 with BYPASS_WB_EN, old value without.
REQ-030 SHALL cover: reset asserted during hazard=1 with taken bne pending -> next cycle all outputs 0, sel_pc=00, registers read 0.
